// File: rtl/bus_memory_responder.sv
// Bus target serving single and burst reads/writes from a 2^ADDR_WIDTH x 32 scratchpad.
// Optional build macro BUS_RESPONDER_BUSY_INJECT_EN: stall every 4th WRITE cycle via busyOUT.
module bus_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  busrt_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {IDLE, WRITE, READ_FETCH, READ, READ_END, ERR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [3:0]            be;
  logic [CNT_W-1:0]      beats, count;
  logic [31:0]           rdata;
  logic [31:0]           mem [DEPTH];

  logic hit, misaligned, wr_busy, wr_accept, rd_consume, rd_last;

  assign hit        = (state == IDLE) && begin_transactionIN &&
                      (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign misaligned = (address_dataIN[1:0] != 2'b00);

`ifdef BUS_RESPONDER_BUSY_INJECT_EN
  // Free-running phase counter, held at zero outside WRITE so each write starts at phase 0.
  logic [1:0] inj_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              inj_cnt <= '0;
    else if (state != WRITE) inj_cnt <= '0;
    else                     inj_cnt <= inj_cnt + 2'd1;
  end
  assign wr_busy = (state == WRITE) && (inj_cnt == 2'd3);
`else
  assign wr_busy = 1'b0;
`endif

  assign wr_accept  = (state == WRITE) && data_validIN && !wr_busy && (count < beats);
  assign rd_consume = (state == READ) && !busyIN;
  assign rd_last    = (count == beats - CNT_W'(1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hit) begin
          if (misaligned)          state_nxt = ERR;
          else if (read_n_writeIN) state_nxt = READ_FETCH;
          else                     state_nxt = WRITE;
        end
      end
      WRITE:      if (end_transactionIN) state_nxt = IDLE;
      READ_FETCH: state_nxt = end_transactionIN ? IDLE : READ;
      READ: begin
        if (end_transactionIN)          state_nxt = IDLE;
        else if (rd_consume && rd_last) state_nxt = READ_END;
      end
      READ_END:   state_nxt = IDLE;
      ERR:        state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode; every output idles at 0 for the wired-OR bus
  always_comb begin
    address_dataOUT    = '0;
    end_transactionOUT = 1'b0;
    data_validOUT      = 1'b0;
    busyOUT            = 1'b0;
    errorOUT           = 1'b0;
    case (state)
      WRITE:    busyOUT = wr_busy;
      READ: begin
        data_validOUT   = 1'b1;
        address_dataOUT = rdata;
      end
      READ_END: end_transactionOUT = 1'b1;
      ERR: begin
        errorOUT           = 1'b1;
        end_transactionOUT = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction context, pointer and read prefetch register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      be    <= '0;
      beats <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          ptr   <= address_dataIN[ADDR_WIDTH+1:2];
          be    <= byte_enableIN;
          beats <= CNT_W'(busrt_sizeIN) + CNT_W'(1);
          count <= '0;
        end
        WRITE: if (wr_accept) begin
          ptr   <= ptr + ADDR_WIDTH'(1);
          count <= count + CNT_W'(1);
        end
        READ_FETCH: begin
          rdata <= mem[ptr];
          ptr   <= ptr + ADDR_WIDTH'(1);
        end
        READ: if (rd_consume) begin
          rdata <= mem[ptr];
          ptr   <= ptr + ADDR_WIDTH'(1);
          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Scratchpad write port with per-lane enables; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ptr][8*i +: 8] <= address_dataIN[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Self-checking bench for bus_memory_responder: decode table, scoreboard on read data, corner sequences.
module tb_bus_memory_responder;

`ifdef BUS_RESPONDER_BUSY_INJECT_EN
  localparam bit INJECT = 1'b1;
`else
  localparam bit INJECT = 1'b0;
`endif

  logic        clock, reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  busrt_sizeIN;
  logic        read_n_writeIN, begin_transactionIN, end_transactionIN, data_validIN, busyIN;
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT, data_validOUT, busyOUT, errorOUT;

  bus_memory_responder dut (
    .clock               (clock),
    .reset               (reset),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .busrt_sizeIN        (busrt_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .address_dataOUT     (address_dataOUT),
    .end_transactionOUT  (end_transactionOUT),
    .data_validOUT       (data_validOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [512];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic        t1_err;
    logic        t1_end;
    logic        t2_valid;
  } dec_vec_t;

  dec_vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_busy(input int c);
    return INJECT && ((c % 4) == 3);
  endfunction

  // Scoreboard: every cycle with valid read data pops one expected word
  always @(negedge clock) begin
    if (reset && data_validOUT) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rdata: got %h want no data at %0t", address_dataOUT, $time);
      end else begin
        chk("rdata", address_dataOUT, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int n,
                          input logic [31:0] base, input int extra);
    logic [8:0]  p;
    logic [31:0] d;
    int          k;
    int          wcyc;
    logic        acc;
    p    = addr[10:2];
    k    = 0;
    wcyc = 0;
    begin_transactionIN = 1'b1;
    address_dataIN      = addr;
    byte_enableIN       = be;
    read_n_writeIN      = 1'b0;
    busrt_sizeIN        = 8'(n - 1);
    tick();
    begin_transactionIN = 1'b0;
    while (k < n) begin
      d              = base + 32'(k);
      address_dataIN = d;
      data_validIN   = 1'b1;
      @(negedge clock);
      chk("busy_pattern", 32'(busyOUT), 32'(exp_busy(wcyc)));
      acc = !exp_busy(wcyc);
      if (acc && k == n - 1 && extra == 0) end_transactionIN = 1'b1;
      if (acc) begin
        for (int i = 0; i < 4; i++) if (be[i]) model[p][8*i +: 8] = d[8*i +: 8];
        p = p + 9'd1;
        k++;
      end
      wcyc++;
      tick();
    end
    for (int e = 0; e < extra; e++) begin
      address_dataIN = ~(base + 32'(e));
      data_validIN   = 1'b1;
      @(negedge clock);
      chk("busy_pattern_extra", 32'(busyOUT), 32'(exp_busy(wcyc)));
      if (e == extra - 1) end_transactionIN = 1'b1;
      wcyc++;
      tick();
    end
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = '0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int nbeats, input int stall_beat,
                         input int stall_cycles, input int abort_after);
    logic [8:0] p;
    int         consumed;
    int         ns;
    p        = addr[10:2];
    consumed = (abort_after > 0) ? abort_after : nbeats;
    begin_transactionIN = 1'b1;
    address_dataIN      = addr;
    byte_enableIN       = 4'hF;
    read_n_writeIN      = 1'b1;
    busrt_sizeIN        = 8'(nbeats - 1);
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    @(negedge clock);
    chk("fetch_quiet", {30'd0, data_validOUT, end_transactionOUT}, 32'd0);
    tick();
    for (int b = 0; b < consumed; b++) begin
      ns = (b == stall_beat) ? stall_cycles : 0;
      for (int s = 0; s <= ns; s++) begin
        busyIN = (s < ns);
        exp_q.push_back(model[p + 9'(b)]);
        tick();
      end
    end
    busyIN = 1'b0;
    if (abort_after > 0) begin
      end_transactionIN = 1'b1;
      busyIN            = 1'b1;
      exp_q.push_back(model[p + 9'(consumed)]);
      tick();
      end_transactionIN = 1'b0;
      busyIN            = 1'b0;
      @(negedge clock);
      chk("abort_data", address_dataOUT, 32'd0);
      chk("abort_quiet", {29'd0, data_validOUT, end_transactionOUT, errorOUT}, 32'd0);
    end else begin
      @(negedge clock);
      chk("read_end", {30'd0, end_transactionOUT, data_validOUT}, 32'd2);
      tick();
      @(negedge clock);
      chk("read_end_one_cycle", 32'(end_transactionOUT), 32'd0);
    end
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h6000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h6000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h4FFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h5000_0800, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h5000_0002, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h5000_07FF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h5000_0004, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    address_dataIN = '0; byte_enableIN = '0; busrt_sizeIN = '0; read_n_writeIN = 1'b0;
    begin_transactionIN = 1'b0; end_transactionIN = 1'b0; data_validIN = 1'b0; busyIN = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_data", address_dataOUT, 32'd0);
    chk("reset_flags", {27'd0, end_transactionOUT, data_validOUT, busyOUT, errorOUT, 1'b0}, 32'd0);
    reset = 1'b1;
    tick();

    // Single write then read back
    do_write(32'h5000_0010, 4'hF, 1, 32'hDEAD_BEEF, 0);
    do_read(32'h5000_0010, 1, -1, 0, 0);

    // Burst write 1..4, burst read with a 3-cycle stall on the second beat
    do_write(32'h5000_0000, 4'hF, 4, 32'd1, 0);
    do_read(32'h5000_0000, 4, 1, 3, 0);

    // Byte-lane merge
    do_write(32'h5000_0020, 4'hF, 1, 32'h1122_3344, 0);
    do_write(32'h5000_0020, 4'b0101, 1, 32'hAABB_CCDD, 0);
    do_read(32'h5000_0020, 1, -1, 0, 0);

    // Beats beyond the burst length are ignored
    do_write(32'h5000_0030, 4'hF, 2, 32'hA0, 0);
    do_write(32'h5000_0030, 4'hF, 1, 32'h1234_5678, 2);
    do_read(32'h5000_0030, 2, -1, 0, 0);

    // Decode / misalignment table
    for (int v = 0; v < 7; v++) begin
      begin_transactionIN = 1'b1;
      address_dataIN      = vecs[v].addr;
      read_n_writeIN      = vecs[v].rnw;
      busrt_sizeIN        = 8'd0;
      byte_enableIN       = 4'hF;
      tick();
      begin_transactionIN = 1'b0;
      address_dataIN      = vecs[v].rnw ? 32'd0 : 32'hFFFF_FFFF;
      data_validIN        = !vecs[v].rnw;
      @(negedge clock);
      chk("dec_t1_err", 32'(errorOUT), 32'(vecs[v].t1_err));
      chk("dec_t1_end", 32'(end_transactionOUT), 32'(vecs[v].t1_end));
      chk("dec_t1_valid", 32'(data_validOUT), 32'd0);
      tick();
      data_validIN   = 1'b0;
      address_dataIN = '0;
      if (vecs[v].t2_valid) exp_q.push_back(model[vecs[v].addr[10:2]]);
      @(negedge clock);
      chk("dec_t2_valid", 32'(data_validOUT), 32'(vecs[v].t2_valid));
      chk("dec_t2_err", {30'd0, errorOUT, end_transactionOUT}, 32'd0);
      tick();
      @(negedge clock);
      chk("dec_t3_end", 32'(end_transactionOUT), 32'(vecs[v].t2_valid));
      tick();
    end
    chk("dec_queue_drained", 32'(exp_q.size()), 32'd0);
    do_read(32'h5000_0000, 2, -1, 0, 0);

    // Wrap at the top of the window, then an aborted long read across the wrap
    do_write(32'h5000_07FC, 4'hF, 3, 32'h0000_0700, 0);
    do_read(32'h5000_07FC, 3, -1, 0, 0);
    do_read(32'h5000_07FC, 8, -1, 0, 2);

    // Reset asserted while read data is on the bus
    begin_transactionIN = 1'b1;
    address_dataIN      = 32'h5000_0000;
    read_n_writeIN      = 1'b1;
    busrt_sizeIN        = 8'd7;
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = '0;
    tick();
    exp_q.push_back(model[0]);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_data", address_dataOUT, 32'd0);
    chk("rst_mid_flags", {28'd0, end_transactionOUT, data_validOUT, busyOUT, errorOUT}, 32'd0);
    tick();
    @(negedge clock);
    chk("rst_hold_valid", 32'(data_validOUT), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    do_read(32'h5000_0010, 1, -1, 0, 0);

    // Eight-beat write (stalled every 4th cycle when injection is built in)
    do_write(32'h5000_0100, 4'hF, 8, 32'hC0DE_0000, 0);
    do_read(32'h5000_0100, 8, -1, 0, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
